// File: rtl/aes_round_seq_if.sv
// Block-in / block-out stream bundle for the iterative AES round sequencer.
//
// Handshake: each side is a valid/ready pair. A transfer happens in the cycle
// where valid=1 and ready=1, sampled at the rising clock edge. A source holds
// valid and its data stable until the transfer. A sink may drive ready
// without looking at valid.
interface aes_round_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    // Producer of plaintext and consumer of ciphertext
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The sequencer itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_round_seq.sv
// Iterative AES encryption sequencer. Owns the 128-bit cipher state and the
// round counter. Round keys come from an external key schedule addressed by
// rk_idx. The SubBytes/ShiftRows/MixColumns cone is also external: it
// receives rf_in and rf_final and returns rf_out in the same cycle.
// Only one block is in flight at a time.
module aes_round_seq #(
    parameter int NR = 10
) (
    input  logic           clk,
    input  logic           rst,
    aes_round_seq_if.slave bus,
    output logic [3:0]     rk_idx,
    input  logic [127:0]   rk,
    output logic [127:0]   rf_in,
    output logic           rf_final,
    input  logic [127:0]   rf_out,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_e       fsm_q;
    logic [127:0] state_q;
    logic [3:0]   round_q;

    // Sequencer. IDLE applies the initial AddRoundKey. Each ROUND cycle folds
    // the cone result with the round key. DONE holds the ciphertext until the
    // consumer takes it. The counter drops back to 0 on entering DONE, so
    // rk_idx reads 0 whenever the FSM is not in ROUND.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= bus.in_data ^ rk;
                        round_q <= 4'd1;
                        fsm_q   <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    state_q <= rf_out ^ rk;
                    if (round_q == LAST_ROUND) begin
                        round_q <= '0;
                        fsm_q   <= ST_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        fsm_q <= ST_IDLE;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    round_q <= '0;
                end
            endcase
        end
    end

    // Outputs decode only the registers. The sole exception is in_ready,
    // which is also masked by rst so that no block is offered acceptance
    // while reset is held.
    assign bus.in_ready  = (fsm_q == ST_IDLE) && !rst;
    assign bus.out_valid = (fsm_q == ST_DONE);
    assign bus.out_data  = state_q;
    assign rf_in         = state_q;
    assign rf_final      = (fsm_q == ST_ROUND) && (round_q == LAST_ROUND);
    assign rk_idx        = round_q;
    assign busy          = (fsm_q != ST_IDLE);
    assign dbg_state     = fsm_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq. Two instances are used: one for AES-128 (NR=10)
// and one for AES-256 (NR=14). The bench supplies a behavioural S-box,
// round cone and key schedule, and a whole-cipher reference model that
// produces the expected ciphertexts.
module tb_aes_round_seq;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    aes_round_seq_if bus_a ();
    aes_round_seq_if bus_b ();

    logic [3:0]   rk_idx_a, rk_idx_b;
    logic [127:0] rk_a, rk_b, rf_in_a, rf_in_b, rf_out_a, rf_out_b;
    logic         rf_final_a, rf_final_b, busy_a, busy_b;
    logic [1:0]   dbg_a, dbg_b;

    aes_round_seq #(.NR(10)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .rk_idx(rk_idx_a), .rk(rk_a), .rf_in(rf_in_a), .rf_final(rf_final_a),
        .rf_out(rf_out_a), .busy(busy_a), .dbg_state(dbg_a)
    );

    aes_round_seq #(.NR(14)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .rk_idx(rk_idx_b), .rk(rk_b), .rf_in(rf_in_b), .rf_final(rf_final_b),
        .rf_out(rf_out_b), .busy(busy_b), .dbg_state(dbg_b)
    );

    // ---------------- AES reference ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, p, e, v;
        r = 8'h01; p = a; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return v;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes, ShiftRows, and MixColumns unless this is the last round
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r+4*c] = sb[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(r+4*c) -: 8] = last ? sr[r+4*c] :
                    gf_mul(sr[r+4*c], 8'h02) ^ gf_mul(sr[(r+1)%4+4*c], 8'h03) ^
                    sr[(r+2)%4+4*c] ^ sr[(r+3)%4+4*c];
        return res;
    endfunction

    // Key expansion; a 128-bit key sits in the upper half of 'key' when nk=4
    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int rnd);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 64; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [255:0] key,
                                             input int nk, input int nr);
        logic [127:0] s;
        s = pt ^ round_key(key, nk, 0);
        for (int r = 1; r <= nr; r++) s = aes_round(s, r == nr) ^ round_key(key, nk, r);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // External key schedule and round cone seen by each DUT
    logic [255:0] key_a, key_b;
    logic [127:0] rkt_a [0:15];
    logic [127:0] rkt_b [0:15];

    assign rk_a     = rkt_a[rk_idx_a];
    assign rk_b     = rkt_b[rk_idx_b];
    assign rf_out_a = aes_round(rf_in_a, rf_final_a);
    assign rf_out_b = aes_round(rf_in_b, rf_final_b);

    task automatic load_keys_a();
        for (int r = 0; r < 16; r++) rkt_a[r] = round_key(key_a, 4, r);
    endtask

    task automatic load_keys_b();
        for (int r = 0; r < 16; r++) rkt_b[r] = round_key(key_b, 8, r);
    endtask

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [127:0] exp_q_a [$];
    int           acc_q_a [$];
    logic         prev_ov_a = 1'b0;
    logic         prev_or_a = 1'b0;
    logic [127:0] prev_od_a = '0;
    bit           rand_bp   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q_a.delete();
            acc_q_a.delete();
            prev_ov_a = 1'b0;
        end else begin
            check("a_rk_idx_range", 128'(rk_idx_a <= 4'd10), 128'(1));
            check("a_ready_valid_excl", 128'(bus_a.in_ready && bus_a.out_valid), 128'(0));
            check("a_busy_not_idle", 128'(busy_a), 128'(!bus_a.in_ready));
            if (prev_ov_a && !prev_or_a) begin
                check("a_hold_valid", 128'(bus_a.out_valid), 128'(1));
                check("a_hold_data", bus_a.out_data, prev_od_a);
            end
            if (bus_a.out_valid && !prev_ov_a) begin
                if (acc_q_a.size() == 0) check("a_unexpected_out", 128'(1), 128'(0));
                else check("a_latency", 128'(cyc - acc_q_a.pop_front()), 128'(11));
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (exp_q_a.size() == 0) check("a_unexpected_data", 128'(1), 128'(0));
                else check("a_out_data", bus_a.out_data, exp_q_a.pop_front());
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                exp_q_a.push_back(aes_enc(bus_a.in_data, key_a, 4, 10));
                acc_q_a.push_back(cyc);
            end
            prev_ov_a = bus_a.out_valid;
            prev_or_a = bus_a.out_ready;
            prev_od_a = bus_a.out_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("b_rk_idx_range", 128'(rk_idx_b <= 4'd14), 128'(1));
            check("b_ready_valid_excl", 128'(bus_b.in_ready && bus_b.out_valid), 128'(0));
            check("b_busy_not_idle", 128'(busy_b), 128'(!bus_b.in_ready));
        end
    end

    // Random consumer backpressure on instance A
    always @(posedge clk) begin
        #1;
        if (rand_bp) bus_a.out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- drivers ----------------
    task automatic send_a(input logic [127:0] d, output int t);
        int n;
        n = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        @(negedge clk);
        while (!bus_a.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_send_timeout", 128'(n < 100), 128'(1));
        t = cyc;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [127:0] d, output int t);
        int n;
        n = 0;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = d;
        @(negedge clk);
        while (!bus_b.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_send_timeout", 128'(n < 100), 128'(1));
        t = cyc;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic wait_out_a(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_a.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("a_out_timeout", 128'(n < 40), 128'(1));
        at = cyc;
    endtask

    task automatic wait_out_b(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_b.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b_out_timeout", 128'(n < 40), 128'(1));
        at = cyc;
    endtask

    task automatic wait_drain_a();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q_a.size() != 0 || busy_a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("a_drain_timeout", 128'(n < 300), 128'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t, at, last, got, n;
        logic [127:0] pt;

        rst = 1'b1;
        bus_a.in_valid = 1'b1; bus_a.in_data = rand128(); bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0;        bus_b.out_ready = 1'b1;
        key_a = {K128, 128'h0}; load_keys_a();
        key_b = K256;           load_keys_b();

        // Reset state, with in_valid asserted to show reset wins
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(bus_a.in_ready), 128'(0));
        check("rst_out_valid", 128'(bus_a.out_valid), 128'(0));
        check("rst_busy", 128'(busy_a), 128'(0));
        check("rst_out_data", bus_a.out_data, 128'(0));
        check("rst_rf_in", rf_in_a, 128'(0));
        check("rst_rf_final", 128'(rf_final_a), 128'(0));
        check("rst_rk_idx", 128'(rk_idx_a), 128'(0));
        check("rst_b_busy", 128'(busy_b), 128'(0));
        check("rst_b_in_ready", 128'(bus_b.in_ready), 128'(0));
        bus_a.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 128'(bus_a.in_ready), 128'(1));
        check("post_rst_busy", 128'(busy_a), 128'(0));
        check("post_rst_b_in_ready", 128'(bus_b.in_ready), 128'(1));

        // Anchor the reference model on the published vectors
        check("model_aes128", aes_enc(PT, key_a, 4, 10), CT128);
        check("model_aes256", aes_enc(PT, key_b, 8, 14), CT256);

        // AES-128 known answer with a ready consumer
        @(posedge clk); #1;
        send_a(PT, t);
        wait_out_a(at);
        check("a_fips_cycle", 128'(at - t), 128'(11));
        check("a_fips_data", bus_a.out_data, CT128);

        // Same vector with the consumer stalled for five cycles
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        send_a(PT, t);
        wait_out_a(at);
        for (int k = 0; k < 5; k++) begin
            check("a_bp_valid", 128'(bus_a.out_valid), 128'(1));
            check("a_bp_data", bus_a.out_data, CT128);
            check("a_bp_in_ready", 128'(bus_a.in_ready), 128'(0));
            @(posedge clk); #1;
        end
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        check("a_done_hs_valid", 128'(bus_a.out_valid), 128'(1));
        check("a_done_hs_in_ready", 128'(bus_a.in_ready), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("a_after_hs_idle", 128'(busy_a), 128'(0));
        check("a_after_hs_in_ready", 128'(bus_a.in_ready), 128'(1));
        check("a_after_hs_out_valid", 128'(bus_a.out_valid), 128'(0));

        // Back-to-back offers: in_valid held high, data held during ROUND
        @(posedge clk); #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = rand128();
        last = -1; got = 0; n = 0;
        while (got < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus_a.in_ready) begin
                if (last >= 0) check("a_b2b_interval", 128'(cyc - last), 128'(12));
                last = cyc;
                got++;
                @(posedge clk); #1;
                bus_a.in_data = rand128();
            end
        end
        bus_a.in_valid = 1'b0;
        check("a_b2b_timeout", 128'(n < 200), 128'(1));
        wait_drain_a();

        // Random keys, plaintexts, gaps and backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            key_a = {rand128(), 128'h0};
            load_keys_a();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_a(rand128(), t);
            wait_drain_a();
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        bus_a.out_ready = 1'b1;

        // Reset in the middle of a block discards it
        key_a = {K128, 128'h0};
        load_keys_a();
        @(posedge clk); #1;
        send_a(PT, t);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("a_midrst_cycle", 128'(cyc - t), 128'(5));
        check("a_midrst_busy_before", 128'(busy_a), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("a_midrst_busy", 128'(busy_a), 128'(0));
        check("a_midrst_out_valid", 128'(bus_a.out_valid), 128'(0));
        check("a_midrst_state", rf_in_a, 128'(0));
        check("a_midrst_out_data", bus_a.out_data, 128'(0));
        check("a_midrst_rk_idx", 128'(rk_idx_a), 128'(0));
        check("a_midrst_rf_final", 128'(rf_final_a), 128'(0));
        check("a_midrst_in_ready", 128'(bus_a.in_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("a_midrst_in_ready_after", 128'(bus_a.in_ready), 128'(1));
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("a_midrst_no_out", 128'(bus_a.out_valid), 128'(0));
        end

        // AES-256 known answer: round-key walk, rf_final placement, latency
        key_b = K256;
        load_keys_b();
        @(posedge clk); #1;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = PT;
        @(negedge clk);
        check("b_accept_ready", 128'(bus_b.in_ready), 128'(1));
        check("b_rk_idx_0", 128'(rk_idx_b), 128'(0));
        t = cyc;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            @(negedge clk);
            check("b_rk_idx", 128'(rk_idx_b), 128'(r));
            check("b_rf_final", 128'(rf_final_b), 128'(r == 14));
            check("b_busy", 128'(busy_b), 128'(1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b_fips_cycle", 128'(cyc - t), 128'(15));
        check("b_fips_valid", 128'(bus_b.out_valid), 128'(1));
        check("b_fips_data", bus_b.out_data, CT256);
        check("b_done_rf_final", 128'(rf_final_b), 128'(0));

        // AES-256 with random keys and plaintexts
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            key_b = {rand128(), rand128()};
            load_keys_b();
            pt = rand128();
            send_b(pt, t);
            wait_out_b(at);
            check("b_rand_latency", 128'(at - t), 128'(15));
            check("b_rand_data", bus_b.out_data, aes_enc(pt, key_b, 8, 14));
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
